// File: rtl/resp_checker_if.sv
// Stimulus/response bundle between a response checker and whatever drives it.
interface resp_checker_if;
   logic        start;
   logic        vld;
   logic [3:0]  vec;
   logic        f;
   logic        busy;
   logic        done;
   logic        pass;
   logic [4:0]  err_cnt;
   logic [15:0] obs_tt;
   logic        first_err_vld;
   logic [3:0]  first_err_vec;
   logic [7:0]  sig;

   modport master (
      output start, vld, vec, f,
      input  busy, done, pass, err_cnt, obs_tt, first_err_vld, first_err_vec, sig
   );
   modport slave (
      input  start, vld, vec, f,
      output busy, done, pass, err_cnt, obs_tt, first_err_vld, first_err_vec, sig
   );
endinterface

// File: rtl/resp_checker.sv
// Collects f responses for all 16 input vectors and compares them against EXP_TT.
// Define RESP_CHECKER_SIG_EN to build the 8-bit response signature MISR.
module resp_checker #(
   parameter logic [15:0] EXP_TT = 16'h6996
) (
   input logic           clk,
   input logic           rst,
   resp_checker_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t      state, nxt;
   logic        busy_q, done_q, pass_q;
   logic        busy_n, done_n, pass_n;
   logic [4:0]  err_q, err_n;
   logic [15:0] obs_q, obs_n, seen_q, seen_n;
   logic        fev_q, fev_n;
   logic [3:0]  fvec_q, fvec_n;
   logic [7:0]  sig_q, sig_n;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt    = state;
      err_n  = err_q;
      obs_n  = obs_q;
      seen_n = seen_q;
      fev_n  = fev_q;
      fvec_n = fvec_q;
      sig_n  = sig_q;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               nxt    = COLLECT;
               err_n  = '0;
               obs_n  = '0;
               seen_n = '0;
               fev_n  = 1'b0;
               fvec_n = '0;
               sig_n  = '0;
            end
         end
         COLLECT: begin
            if (bus.vld) begin
               obs_n[bus.vec]  = bus.f;
               seen_n[bus.vec] = 1'b1;
               if (bus.f != EXP_TT[bus.vec]) begin
                  err_n = (err_q == 5'd31) ? err_q : err_q + 5'd1;
                  if (!fev_q) begin
                     fev_n  = 1'b1;
                     fvec_n = bus.vec;
                  end
               end
`ifdef RESP_CHECKER_SIG_EN
               sig_n = {sig_q[6:0], sig_q[7]} ^ {3'b000, bus.f, bus.vec};
`endif
               // the completing sample is fully recorded before the move to DONE
               if (&seen_n) nxt = DONE;
            end
         end
         default: nxt = IDLE;
      endcase
      busy_n = (nxt == COLLECT);
      done_n = (nxt == DONE);
      pass_n = done_n && (err_n == 5'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         err_q  <= '0;
         obs_q  <= '0;
         seen_q <= '0;
         fev_q  <= 1'b0;
         fvec_q <= '0;
      end else begin
         busy_q <= busy_n;
         done_q <= done_n;
         pass_q <= pass_n;
         err_q  <= err_n;
         obs_q  <= obs_n;
         seen_q <= seen_n;
         fev_q  <= fev_n;
         fvec_q <= fvec_n;
      end
   end

`ifdef RESP_CHECKER_SIG_EN
   always_ff @(posedge clk) begin
      if (rst) sig_q <= '0;
      else     sig_q <= sig_n;
   end
`else
   assign sig_q = 8'h00;
`endif

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.err_cnt       = err_q;
   assign bus.obs_tt        = obs_q;
   assign bus.first_err_vld = fev_q;
   assign bus.first_err_vec = fvec_q;
   assign bus.sig           = sig_q;
endmodule

// File: doc/resp_checker.md
RESP_CHECKER -- requirements
Module: resp_checker

Interface
REQ-001 SHALL provide parameter EXP_TT, default 16'h6996, expected DUT output per vector; bit i is the expected f for vec==i.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port start  input  1  begin a new collection run.
REQ-005 SHALL provide port vld  input  1  vec/f sample valid this cycle.
REQ-006 SHALL provide port vec  input  4  applied stimulus {A,B,C,D}, A is MSB.
REQ-007 SHALL provide port f  input  1  observed DUT response for vec.
REQ-008 SHALL provide port busy  output  1  high in COLLECT.
REQ-009 SHALL provide port done  output  1  high in DONE (level).
REQ-010 SHALL provide port pass  output  1  high in DONE when err_cnt==0.
REQ-011 SHALL provide port err_cnt  output  5  mismatch count, saturating.
REQ-012 SHALL provide port obs_tt  output  16  captured truth table, bit i is last f seen for vec==i.
REQ-013 SHALL provide port first_err_vld  output  1  at least one mismatch recorded this run.
REQ-014 SHALL provide port first_err_vec  output  4  vec of first mismatch this run.
REQ-015 SHALL provide port sig  output  8  response signature (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, DONE; outputs registered.
REQ-017 IDLE: start -> COLLECT next cycle; clears obs_tt, internal 16-bit seen mask, err_cnt, first_err_vld, first_err_vec, sig.
REQ-018 DONE: start -> COLLECT with identical clearing; otherwise hold DONE and all results.
REQ-019 COLLECT: start ignored; vld ignored in IDLE and DONE; start has priority over vld in same cycle.
REQ-020 COLLECT, vld=1: obs_tt[vec]<=f, seen[vec]<=1; duplicate vectors allowed, last f wins.
REQ-021 Mismatch (f != EXP_TT[vec]) on any vld sample, duplicates included: err_cnt+1, saturating at 31.
REQ-022 First mismatch of a run: first_err_vld<=1, first_err_vec<=vec; later mismatches do not alter them.
REQ-023 Sample that makes seen==16'hFFFF: SHALL be fully accounted, FSM enters DONE next cycle; done asserts one cycle after that sample.
REQ-024 pass SHALL be 0 outside DONE.

Reset
REQ-025 rst=1 at any clock edge, including mid-COLLECT, SHALL force IDLE and busy=0, done=0, pass=0, err_cnt=0, obs_tt=0, seen=0, first_err_vld=0, first_err_vec=0, sig=0.
REQ-026 rst SHALL take priority over start and vld.

Configuration
REQ-027 Macro RESP_CHECKER_SIG_EN defined: each accepted vld sample SHALL update sig <= {sig[6:0],sig[7]} ^ {3'b000,f,vec}; seed 8'h00 on start/reset.
REQ-028 Macro undefined: sig port SHALL remain, tied to 8'h00; no MISR logic.

Verification
REQ-029 rst; start; vec 0..15 ascending one per cycle, f=EXP_TT[vec] -> done 1 cycle after vec15, pass=1, err_cnt=0, obs_tt=16'h6996, first_err_vld=0, sig=8'h00.
REQ-030 As REQ-029 with f inverted at vec 5 -> err_cnt=1, pass=0, first_err_vec=5, obs_tt=16'h69B6, sig=8'h40 with macro, 8'h00 without.
REQ-031 start; vec 0 three times with f=1, then 0..15 correct -> err_cnt=3, first_err_vec=0, obs_tt=16'h6996, pass=0.
REQ-032 start; vec 0 with f=1 for 35 cycles, then 1..15 correct -> err_cnt=31 (saturated), done asserted, pass=0.
REQ-033 start; vec 0..7 correct; rst one cycle -> all outputs 0, IDLE; start; 0..15 correct -> pass=1; start during COLLECT and vld in IDLE/DONE have no effect.
